// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU (read-only) and the LSU
// (read/write). Round-robin on ties, one outstanding transaction, response
// routed to the owner only, watchdog converts a hung WAIT into an error.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_W-1:0]     ifu_rsp_data,
  output logic                  ifu_rsp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_W-1:0]     lsu_rsp_data,
  output logic                  lsu_rsp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_nx;
  logic                owner_lsu;   // 1: LSU owns the transaction, 0: IFU
  logic                last_lsu;    // last grant went to the LSU
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                grant_ifu, grant_lsu;
  logic                rsp_fire, rsp_err;

  // State register and watchdog counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Latch the winning request and remember who owns it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_lsu <= 1'b0;
      last_lsu  <= 1'b1;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_ifu) begin
      owner_lsu <= 1'b0;
      last_lsu  <= 1'b0;
      mem_addr  <= ifu_addr;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_lsu) begin
      owner_lsu <= 1'b1;
      last_lsu  <= 1'b1;
      mem_addr  <= lsu_addr;
      mem_wen   <= lsu_wen;
      mem_wdata <= lsu_wdata;
      mem_wmask <= lsu_wmask;
    end
  end

  // Arbitration, next state, response/timeout detection
  always_comb begin
    state_nx  = state;
    cnt_nx    = '0;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    rsp_fire  = 1'b0;
    rsp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ifu_req_valid && (!lsu_req_valid || last_lsu)) grant_ifu = 1'b1;
        else if (lsu_req_valid)                           grant_lsu = 1'b1;
        if (grant_ifu || grant_lsu) state_nx = ISSUE;
      end
      ISSUE: begin
        if (mem_req_ready) state_nx = WAIT;
      end
      WAIT: begin
        // A real response takes priority over a same-cycle timeout
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          state_nx = IDLE;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output routing; readies are masked while reset is held because IDLE
  // arbitration would otherwise still see incoming requests
  always_comb begin
    ifu_req_ready = grant_ifu & ~rst;
    lsu_req_ready = grant_lsu & ~rst;
    mem_req_valid = (state == ISSUE);
    ifu_rsp_valid = rsp_fire & ~owner_lsu;
    lsu_rsp_valid = rsp_fire & owner_lsu;
    ifu_rsp_err   = rsp_err & ~owner_lsu;
    lsu_rsp_err   = rsp_err & owner_lsu;
    ifu_rsp_data  = (ifu_rsp_valid && !rsp_err) ? mem_rsp_data : '0;
    lsu_rsp_data  = (lsu_rsp_valid && !rsp_err) ? mem_rsp_data : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued on grant
// and popped when either response port pulses.
module tb_mem_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid = 1'b0, ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_rsp_valid, ifu_rsp_err;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid = 1'b0, lsu_req_ready;
  logic [AW-1:0] lsu_addr = '0;
  logic          lsu_wen = 1'b0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_wmask = '0;
  logic          lsu_rsp_valid, lsu_rsp_err;
  logic [DW-1:0] lsu_rsp_data;
  logic          mem_req_valid, mem_wen;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            lsu;
    logic [DW-1:0] data;
    bit            err;
    bit            chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h13;
    return {~a[31:0], a[31:0]};
  endfunction

  // Memory model knobs
  int unsigned   stall_cycles = 0;
  int unsigned   rsp_delay = 0;
  bit            mute = 1'b0;
  int            inj_req = 0;
  int            inj_done = 0;
  bit            pend = 1'b0;
  int unsigned   pend_cnt = 0;
  int unsigned   stall_cnt = 0;
  logic [AW-1:0] pend_addr = '0;

  // Downstream memory: optional request stall, response after rsp_delay
  // extra cycles, optional one-shot spurious response
  initial begin
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (inj_done != inj_req) begin
        inj_done      = inj_req;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hBAD;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          pend = 1'b0;
          if (!mute) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_addr);
          end
        end else pend_cnt--;
      end
      if (mem_req_valid && stall_cnt >= stall_cycles) mem_req_ready = 1'b1;
      else begin
        mem_req_ready = 1'b0;
        if (mem_req_valid) stall_cnt++;
        else stall_cnt = 0;
      end
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        pend      = 1'b1;
        pend_cnt  = rsp_delay;
        pend_addr = mem_addr;
        stall_cnt = 0;
      end
    end
  end

  // Response monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      check("rsp_onehot", 64'(ifu_rsp_valid & lsu_rsp_valid), 64'd0);
      if (exp_q.size() == 0) check("rsp_unexpected", 64'({lsu_rsp_valid, ifu_rsp_valid}), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("rsp_port", 64'(lsu_rsp_valid), 64'(e.lsu));
        check("rsp_err", 64'(e.lsu ? lsu_rsp_err : ifu_rsp_err), 64'(e.err));
        if (e.chk_data) check("rsp_data", e.lsu ? lsu_rsp_data : ifu_rsp_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input bit lsu, input logic [DW-1:0] data, input bit err, input bit chk);
    exp_t e;
    e.lsu = lsu; e.data = data; e.err = err; e.chk_data = chk;
    exp_q.push_back(e);
  endtask

  // cyc = number of cycles before the grant (0 = granted in the current cycle)
  task automatic wait_grant(input int budget, output bit lsu, output int cyc);
    bit got = 1'b0;
    lsu = 1'b0;
    for (cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (ifu_req_ready || lsu_req_ready) begin
        check("ready_onehot", 64'(ifu_req_ready & lsu_req_ready), 64'd0);
        lsu = lsu_req_ready;
        got = 1'b1;
        break;
      end
    end
    if (!got) check("grant_timeout", 64'(cyc), 64'd0);
  endtask

  // cyc = negedges waited until a response pulse
  task automatic wait_rsp(input int budget, output int cyc);
    bit got = 1'b0;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) check("rsp_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x1 expected 0x0");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit who;
    int cyc;

    // Reset values with both requests pending
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 64'h1000; lsu_addr = 64'h2000;
    #2;
    check("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    check("rst_valid", 64'({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_fields", 64'({mem_wen, mem_wmask}), 64'd0);
    check("rst_rsp_data", ifu_rsp_data | lsu_rsp_data | mem_wdata, 64'd0);
    tick();
    rst = 1'b0;

    // Round-robin with both held high: IFU, LSU, IFU, LSU
    for (int k = 0; k < 4; k++) begin
      wait_grant(20, who, cyc);
      check("rr_grant", 64'(who), 64'(k % 2));
      check("rr_prior_done", 64'(exp_q.size()), 64'd0);
      push(who, mem_word(who ? lsu_addr : ifu_addr), 1'b0, 1'b1);
    end
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    wait_drain(20);

    // IFU only, minimum latency
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
    wait_grant(10, who, cyc);
    check("ifu_grant_port", 64'(who), 64'd0);
    check("ifu_accept_cycle", 64'(cyc), 64'd0);
    push(1'b0, 64'h13, 1'b0, 1'b1);
    tick();
    ifu_req_valid = 1'b0; ifu_addr = 64'hFFFF;
    @(negedge clk);
    check("ifu_c1_valid", 64'(mem_req_valid), 64'd1);
    check("ifu_c1_addr", mem_addr, 64'h8000_0000);
    check("ifu_c1_wen_mask", 64'({mem_wen, mem_wmask}), 64'd0);
    wait_rsp(10, cyc);
    check("ifu_rsp_latency", 64'(cyc), 64'd1);
    wait_drain(5);

    // LSU write with three stalled request cycles
    stall_cycles = 3;
    tick();
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    wait_grant(10, who, cyc);
    check("wr_grant_port", 64'(who), 64'd1);
    push(1'b1, '0, 1'b0, 1'b0);
    tick();
    lsu_req_valid = 1'b0; lsu_addr = 64'h1; lsu_wen = 1'b0; lsu_wdata = '1; lsu_wmask = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wr_req_valid", 64'(mem_req_valid), 64'd1);
      check("wr_addr", mem_addr, 64'h8000_1000);
      check("wr_wdata", mem_wdata, 64'hDEAD_BEEF);
      check("wr_wmask_wen", 64'({mem_wmask, mem_wen}), 64'({8'h0F, 1'b1}));
    end
    wait_rsp(10, cyc);
    check("wr_rsp_latency", 64'(cyc), 64'd1);
    check("wr_req_dropped", 64'(mem_req_valid), 64'd0);
    stall_cycles = 0;
    wait_drain(5);

    // Spurious response in IDLE
    inj_req++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("spur_idle", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    end

    // Spurious response in ISSUE
    stall_cycles = 2;
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 64'h3000;
    wait_grant(10, who, cyc);
    push(1'b0, mem_word(64'h3000), 1'b0, 1'b1);
    inj_req++;
    tick();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("spur_issue", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    check("spur_issue_valid", 64'(mem_req_valid), 64'd1);
    wait_rsp(10, cyc);
    check("spur_rsp_latency", 64'(cyc), 64'd3);
    stall_cycles = 0;
    wait_drain(5);

    // Watchdog: memory silent, error on the 4th WAIT cycle, next request next cycle
    mute = 1'b1;
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 64'h4000;
    wait_grant(10, who, cyc);
    push(1'b0, '0, 1'b1, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 64'h5000; lsu_wen = 1'b0;
    wait_rsp(20, cyc);
    check("to_latency", 64'(cyc), 64'd5);
    check("to_no_accept_in_wait", 64'(lsu_req_ready), 64'd0);
    wait_grant(10, who, cyc);
    check("to_next_port", 64'(who), 64'd1);
    check("to_next_cycle", 64'(cyc), 64'd0);
    push(1'b1, '0, 1'b1, 1'b1);
    tick();
    lsu_req_valid = 1'b0;
    wait_drain(20);
    mute = 1'b0;

    // Async reset during WAIT, late response must be dropped, first tie to IFU
    rsp_delay = 3;
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 64'h6000;
    wait_grant(10, who, cyc);
    push(1'b0, mem_word(64'h6000), 1'b0, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 64'h7000;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    check("arst_valid", 64'({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    lsu_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    rsp_delay = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arst_late_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    end
    tick();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 64'h8000; lsu_addr = 64'h9000;
    wait_grant(10, who, cyc);
    check("arst_first_tie", 64'(who), 64'd0);
    push(1'b0, mem_word(64'h8000), 1'b0, 1'b1);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    wait_drain(20);

    repeat (3) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the core's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between IFU/LSU and the memory interface inside top.
- Round-robin on simultaneous requests, one outstanding transaction at a time.
- Response is routed back to the owner only.
- A watchdog terminates hung transactions with an error response.

Parameters:
ADDR_W, 64, address width (matches ImmWidth)
DATA_W, 64, data width; must be a multiple of 8
TIMEOUT, 255, max cycles in WAIT before error; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU address
ifu_rsp_valid  out  1  IFU response pulse
ifu_rsp_data  out  DATA_W  IFU read data
ifu_rsp_err  out  1  IFU response is a timeout error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1=write, 0=read
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  DATA_W/8  byte write mask
lsu_rsp_valid  out  1  LSU response pulse
lsu_rsp_data  out  DATA_W  LSU read data (don't-care for writes)
lsu_rsp_err  out  1  LSU response is a timeout error
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  downstream accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable (0 for IFU)
mem_wdata  out  DATA_W  latched write data
mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
mem_rsp_valid  in  1  downstream response
mem_rsp_data  in  DATA_W  downstream read data

Behaviour:
- Reset (async, rst=1): state=IDLE; owner=none; last_grant=LSU (so IFU wins the first tie); timeout counter=0; latched request regs=0.
- Reset outputs: all *_ready, *_valid and *_err low; data outputs 0.
- Reset mid-transaction abandons it: no response is delivered and mem_req_valid drops immediately.
- States:
  - IDLE: arbitrate combinationally. The winner's *_req_ready=1 in the same cycle as its *_req_valid. On the clock edge: latch addr/wen/wdata/wmask (IFU forces wen=0, wmask=0), set owner, set last_grant=owner, go to ISSUE. With no request, stay in IDLE. At most one ready is asserted per cycle.
  - Tie rule: both valid → grant the requester that is not last_grant. Single valid → grant it regardless of last_grant.
  - ISSUE: mem_req_valid=1 with the latched fields stable. On mem_req_ready=1 go to WAIT and clear the counter. Request fields must not change while valid and not ready.
  - WAIT: mem_req_valid=0. On mem_rsp_valid=1, owner's *_rsp_valid=1 and *_rsp_data=mem_rsp_data combinationally in the same cycle, *_rsp_err=0, then IDLE. The non-owner's rsp_valid stays 0.
    - Each WAIT cycle without a response increments the counter.
    - If TIMEOUT≠0 and counter==TIMEOUT-1 with no response: owner gets rsp_valid=1, rsp_err=1, rsp_data=0 that cycle, then IDLE.
    - A response and the timeout in the same cycle: the real response wins (err=0).
- mem_rsp_valid in IDLE or ISSUE is ignored (no forwarding, no state change).
- Requests in ISSUE/WAIT are not accepted (both readies 0); requesters hold valid.
- Minimum latency, accept to response: 2 cycles (accept in cycle 0, mem_req handshake in cycle 1, response in cycle 2). Back-to-back accept is possible in the cycle after the response.
- Counter width is ceil(log2(TIMEOUT+1)); it is held at 0 outside WAIT.

Test Plan:
- IFU only: ifu_req_valid=1, addr=0x80000000; mem ready immediately, rsp one cycle later with data 0x00000013 → ifu_req_ready in cycle 0, mem_addr=0x80000000/mem_wen=0 in cycle 1, ifu_rsp_valid=1 with data 0x13 in cycle 2, lsu_rsp_valid=0 throughout.
- Simultaneous IFU+LSU after reset, both held high → grants in order IFU, LSU, IFU, LSU (round-robin), each waiting for the prior response.
- LSU write: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F; mem_req_ready low for 3 cycles → mem fields stable and mem_req_valid high for 4 cycles, then lsu_rsp_valid pulse once.
- Timeout: TIMEOUT=4, mem never responds → owner rsp_valid=1 and rsp_err=1 on the 4th WAIT cycle, return to IDLE; a new request is accepted next cycle.
- Reset during WAIT: assert rst asynchronously mid-cycle → mem_req_valid, readies and rsp_valid go 0 immediately; after release, a late mem_rsp_valid produces no response; the first tie is granted to IFU.
- Spurious mem_rsp_valid in IDLE/ISSUE → no rsp_valid on either port, state unaffected.
